fir_norm_seq_ctrl: RTL

//  Run-level sequencer for the 11-channel FIR+normalizer datapath (176-bit packed input, 11x16).

---
 rtl/fir_norm_seq_ctrl_pkg.sv | 25 ++
 rtl/fir_norm_seq_ctrl_timer.sv | 26 ++
 rtl/fir_norm_seq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fir_norm_seq_ctrl_pkg.sv
// Shared definitions for the FIR+normalizer run sequencer: state
// encodings, datapath defaults and a constant clog2 used to size counters.
package fir_norm_seq_ctrl_pkg;

  localparam int DEF_DW  = 176;   // 11 channels x 16 bits
  localparam int DEF_CNT = 1000;  // words per frame, matches the normalizer

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_FDONE = 3'd4
  } state_t;

  // Bits needed to hold the values 0..v-1 (at least 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((32'sd1 <<< i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fir_norm_seq_ctrl_timer.sv
// fir_norm_seq_timer: loadable up-counter with a terminal-count flag.
// Used by the sequencer to bound how long DRAIN waits for the end flag.
module fir_norm_seq_timer #(
  parameter int          W    = 12,
  parameter int unsigned TERM = 4094
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  // load has priority; otherwise count while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt + W'(1);
  end

  assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/fir_norm_seq_ctrl.sv
// fir_norm_seq_ctrl: run-level sequencer for the 11-channel FIR+normalizer.
// Issues a start pulse per frame, meters exactly CNT upstream words into
// the datapath, waits (bounded) for the frame end flag, and reports
// frame/run completion plus a sticky timeout error.
// Optional build macro: FIR_NORM_SEQ_STATS_EN enables the per-frame
// output-valid counter on stat_out_cnt (tied to 0 otherwise).
module fir_norm_seq_ctrl
  import fir_norm_seq_ctrl_pkg::*;
#(
  parameter int CNT      = DEF_CNT,
  parameter int DW       = DEF_DW,
  parameter int FRAMES_W = 8,
  parameter int TIMEOUT  = 4095
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FRAMES_W-1:0] cfg_frames,
  input  logic                run_req,
  input  logic                abort,
  input  logic [DW-1:0]       s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic                fir_start_flag,
  output logic [DW-1:0]       fir_data_in,
  output logic                fir_data_in_valid,
  input  logic                fir_data_out_valid,
  input  logic                fir_process_end_flag,
  output logic                busy,
  output logic [FRAMES_W-1:0] frame_idx,
  output logic                frame_done,
  output logic                run_done,
  output logic                err_timeout,
  output logic [15:0]         stat_out_cnt
);

  localparam int CW = clog2(CNT);
  localparam int TW = clog2(TIMEOUT);

  state_t              state, nstate;
  logic [CW-1:0]       smp_cnt;
  logic [FRAMES_W-1:0] frames_q;
  logic                accept, last_word, last_frame, tmo_tc;

  assign s_tready       = (state == S_FEED);
  assign accept         = s_tvalid & s_tready;
  assign last_word      = (smp_cnt == CW'(CNT - 1));
  assign last_frame     = (frame_idx == frames_q - FRAMES_W'(1));
  assign fir_start_flag = (state == S_START);

  // DRAIN watchdog: held at 0 outside DRAIN, counts every DRAIN cycle
  fir_norm_seq_timer #(.W(TW), .TERM(TIMEOUT - 1)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state != S_DRAIN),
    .load_val ('0),
    .en       (state == S_DRAIN),
    .tc       (tmo_tc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  // next state and completion pulses; abort overrides everything
  always_comb begin
    nstate     = state;
    frame_done = 1'b0;
    run_done   = 1'b0;
    case (state)
      S_IDLE:  if (run_req) nstate = S_START;
      S_START: nstate = S_FEED;
      S_FEED:  if (accept && last_word) nstate = S_DRAIN;
      S_DRAIN: begin
        // end flag wins over a coincident terminal count
        if (fir_process_end_flag) nstate = S_FDONE;
        else if (tmo_tc) begin
          nstate   = S_IDLE;
          run_done = 1'b1;
        end
      end
      S_FDONE: begin
        frame_done = 1'b1;
        if (last_frame) begin
          nstate   = S_IDLE;
          run_done = 1'b1;
        end else begin
          nstate = S_START;
        end
      end
      default: nstate = S_IDLE;
    endcase
    if (abort) begin
      nstate     = S_IDLE;
      frame_done = 1'b0;
      run_done   = busy;
    end
  end

  // run bookkeeping: busy, frame config/index, sticky timeout error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      frames_q    <= '0;
      frame_idx   <= '0;
      err_timeout <= 1'b0;
    end else begin
      busy <= (nstate != S_IDLE);
      if (!abort) begin
        if (state == S_IDLE && run_req) begin
          frames_q    <= (cfg_frames == '0) ? FRAMES_W'(1) : cfg_frames;
          frame_idx   <= '0;
          err_timeout <= 1'b0;
        end
        if (state == S_DRAIN && !fir_process_end_flag && tmo_tc)
          err_timeout <= 1'b1;
        if (state == S_FDONE && !last_frame)
          frame_idx <= frame_idx + FRAMES_W'(1);
      end
    end
  end

  // per-frame word meter and registered word/valid to the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt           <= '0;
      fir_data_in       <= '0;
      fir_data_in_valid <= 1'b0;
    end else begin
      if (state == S_START)  smp_cnt <= '0;
      else if (accept)       smp_cnt <= smp_cnt + CW'(1);
      fir_data_in_valid <= accept & ~abort;
      if (accept && !abort)  fir_data_in <= s_tdata;
    end
  end

`ifdef FIR_NORM_SEQ_STATS_EN
  logic [15:0] out_acc, acc_nxt;

  // saturating add of this cycle's output valid
  always_comb begin
    acc_nxt = out_acc;
    if (fir_data_out_valid && out_acc != 16'hFFFF) acc_nxt = out_acc + 16'd1;
  end

  // accumulate START..FDONE, publish at FDONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_acc      <= '0;
      stat_out_cnt <= '0;
    end else begin
      if (state == S_START)
        out_acc <= fir_data_out_valid ? 16'd1 : 16'd0;
      else if (state == S_FEED || state == S_DRAIN)
        out_acc <= acc_nxt;
      if (state == S_FDONE && !abort)
        stat_out_cnt <= acc_nxt;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = fir_data_out_valid;
  assign stat_out_cnt = '0;
`endif

endmodule
